noc_mem_arbiter: RTL



---
 rtl/alchemist_noc_pkg.sv | 29 ++
 rtl/qos_rr_picker.sv | 41 ++++
 rtl/noc_mem_arbiter.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/alchemist_noc_pkg.sv
// Shared types for the NoC-to-memory arbitration path: request/response
// records, QoS width and the arbiter FSM state encoding.
package alchemist_noc_pkg;

    localparam int unsigned QOS_WIDTH      = 4;
    localparam int unsigned NOC_ADDR_WIDTH = 56;
    localparam int unsigned NOC_DATA_WIDTH = 128;
    localparam int unsigned NOC_STRB_WIDTH = NOC_DATA_WIDTH / 8;

    typedef struct packed {
        logic                      we;
        logic [NOC_ADDR_WIDTH-1:0] addr;
        logic [NOC_DATA_WIDTH-1:0] wdata;
        logic [NOC_STRB_WIDTH-1:0] wstrb;
        logic [QOS_WIDTH-1:0]      qos;
    } noc_request_t;

    typedef struct packed {
        logic [NOC_DATA_WIDTH-1:0] rdata;
        logic                      error;
    } noc_response_t;

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StResp
    } arb_state_e;

endpackage

// File: rtl/qos_rr_picker.sv
// Combinational picker: highest QoS among requesters wins, ties resolved by
// scanning upward from the port after the previous grant.
module qos_rr_picker
    import alchemist_noc_pkg::*;
#(
    parameter int unsigned NUM_PORTS = 11,
    parameter int unsigned IDX_W     = $clog2(NUM_PORTS)
) (
    input  logic [NUM_PORTS-1:0]                req_i,
    input  logic [NUM_PORTS-1:0][QOS_WIDTH-1:0] qos_i,
    input  logic [IDX_W-1:0]                    last_grant_i,
    output logic                                valid_o,
    output logic [IDX_W-1:0]                    winner_o
);

    logic [QOS_WIDTH-1:0] max_qos;
    logic [IDX_W-1:0]     idx;
    logic                 found;

    always_comb begin
        valid_o  = |req_i;
        max_qos  = '0;
        idx      = '0;
        found    = 1'b0;
        winner_o = '0;
        for (int i = 0; i < int'(NUM_PORTS); i++) begin
            if (req_i[i] && (qos_i[i] > max_qos)) begin
                max_qos = qos_i[i];
            end
        end
        // First requester at max QoS, starting one past the last grant.
        for (int k = 1; k <= int'(NUM_PORTS); k++) begin
            idx = IDX_W'((32'(last_grant_i) + 32'(k)) % NUM_PORTS);
            if (!found && req_i[idx] && (qos_i[idx] == max_qos)) begin
                found    = 1'b1;
                winner_o = idx;
            end
        end
    end

endmodule

// File: rtl/noc_mem_arbiter.sv
// Arbitrates NoC request ports onto a single memory channel with one
// outstanding transaction, QoS/round-robin selection and an ack timeout.
module noc_mem_arbiter
    import alchemist_noc_pkg::*;
#(
    parameter int unsigned NUM_PORTS      = 11,
    parameter int unsigned ADDR_WIDTH     = 56,
    parameter int unsigned DATA_WIDTH     = 128,
    parameter int unsigned STRB_WIDTH     = DATA_WIDTH / 8,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [NUM_PORTS-1:0]                 req_i,
    input  logic [NUM_PORTS-1:0]                 we_i,
    input  logic [NUM_PORTS-1:0][ADDR_WIDTH-1:0] addr_i,
    input  logic [NUM_PORTS-1:0][DATA_WIDTH-1:0] wdata_i,
    input  logic [NUM_PORTS-1:0][STRB_WIDTH-1:0] wstrb_i,
    input  logic [NUM_PORTS-1:0][QOS_WIDTH-1:0]  qos_i,
    output logic [NUM_PORTS-1:0]                 ack_o,
    output logic [DATA_WIDTH-1:0]                rdata_o,
    output logic                                 error_o,
    output logic                                 mem_req,
    output logic                                 mem_we,
    output logic [ADDR_WIDTH-1:0]                mem_addr,
    output logic [DATA_WIDTH-1:0]                mem_wdata,
    output logic [STRB_WIDTH-1:0]                mem_wstrb,
    input  logic [DATA_WIDTH-1:0]                mem_rdata,
    input  logic                                 mem_ack,
    output logic [15:0]                          timeout_count
);

    localparam int unsigned IDX_W = $clog2(NUM_PORTS);
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES);

    arb_state_e           state_q, state_d;
    logic [IDX_W-1:0]     last_grant_q, last_grant_d;
    logic [CNT_W-1:0]     wait_cnt_q, wait_cnt_d;
    logic [NUM_PORTS-1:0] ack_q, ack_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                 error_q, error_d;
    logic                 mem_req_q, mem_req_d;
    logic                 mem_we_q, mem_we_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
    logic [STRB_WIDTH-1:0] mem_wstrb_q, mem_wstrb_d;
    logic [15:0]          timeout_cnt_q, timeout_cnt_d;

    logic             pick_valid;
    logic [IDX_W-1:0] pick_winner;

    qos_rr_picker #(
        .NUM_PORTS (NUM_PORTS),
        .IDX_W     (IDX_W)
    ) u_picker (
        .req_i        (req_i),
        .qos_i        (qos_i),
        .last_grant_i (last_grant_q),
        .valid_o      (pick_valid),
        .winner_o     (pick_winner)
    );

    always_comb begin
        state_d       = state_q;
        last_grant_d  = last_grant_q;
        wait_cnt_d    = wait_cnt_q;
        ack_d         = '0;
        rdata_d       = rdata_q;
        error_d       = error_q;
        mem_req_d     = mem_req_q;
        mem_we_d      = mem_we_q;
        mem_addr_d    = mem_addr_q;
        mem_wdata_d   = mem_wdata_q;
        mem_wstrb_d   = mem_wstrb_q;
        timeout_cnt_d = timeout_cnt_q;
        unique case (state_q)
            StIdle: begin
                if (pick_valid) begin
                    mem_req_d    = 1'b1;
                    mem_we_d     = we_i[pick_winner];
                    mem_addr_d   = addr_i[pick_winner];
                    mem_wdata_d  = wdata_i[pick_winner];
                    mem_wstrb_d  = wstrb_i[pick_winner];
                    last_grant_d = pick_winner;
                    wait_cnt_d   = '0;
                    state_d      = StWait;
                end
            end
            StWait: begin
                wait_cnt_d = wait_cnt_q + 1'b1;
                // A coincident ack takes precedence over the timeout.
                if (mem_ack) begin
                    mem_req_d           = 1'b0;
                    rdata_d             = mem_rdata;
                    error_d             = 1'b0;
                    ack_d[last_grant_q] = 1'b1;
                    state_d             = StResp;
                end else if (wait_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    mem_req_d           = 1'b0;
                    rdata_d             = '0;
                    error_d             = 1'b1;
                    ack_d[last_grant_q] = 1'b1;
                    if (timeout_cnt_q != 16'hFFFF) begin
                        timeout_cnt_d = timeout_cnt_q + 16'd1;
                    end
                    state_d = StResp;
                end
            end
            StResp: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= StIdle;
            last_grant_q  <= IDX_W'(NUM_PORTS - 1);
            wait_cnt_q    <= '0;
            ack_q         <= '0;
            rdata_q       <= '0;
            error_q       <= 1'b0;
            mem_req_q     <= 1'b0;
            mem_we_q      <= 1'b0;
            mem_addr_q    <= '0;
            mem_wdata_q   <= '0;
            mem_wstrb_q   <= '0;
            timeout_cnt_q <= '0;
        end else begin
            state_q       <= state_d;
            last_grant_q  <= last_grant_d;
            wait_cnt_q    <= wait_cnt_d;
            ack_q         <= ack_d;
            rdata_q       <= rdata_d;
            error_q       <= error_d;
            mem_req_q     <= mem_req_d;
            mem_we_q      <= mem_we_d;
            mem_addr_q    <= mem_addr_d;
            mem_wdata_q   <= mem_wdata_d;
            mem_wstrb_q   <= mem_wstrb_d;
            timeout_cnt_q <= timeout_cnt_d;
        end
    end

    assign ack_o         = ack_q;
    assign rdata_o       = rdata_q;
    assign error_o       = error_q;
    assign mem_req       = mem_req_q;
    assign mem_we        = mem_we_q;
    assign mem_addr      = mem_addr_q;
    assign mem_wdata     = mem_wdata_q;
    assign mem_wstrb     = mem_wstrb_q;
    assign timeout_count = timeout_cnt_q;

endmodule
